// File: rtl/updi_pkg.sv
// Shared UPDI types: instruction opcodes, pointer/size codes,
// memory-reader sequencer states and handshake helper phases.
package updi_pkg;

    typedef enum logic [3:0] {
        UPDI_LDS    = 4'd0,
        UPDI_STS    = 4'd1,
        UPDI_LD     = 4'd2,
        UPDI_ST     = 4'd3,
        UPDI_ST_PTR = 4'd4,
        UPDI_LDCS   = 4'd5,
        UPDI_STCS   = 4'd6,
        UPDI_REPEAT = 4'd7,
        UPDI_KEY    = 4'd8
    } updi_instruction;

    localparam logic [1:0] UPDI_PTR_ADDRESS = 2'b10;
    localparam logic [1:0] UPDI_PTR_INC     = 2'b01;
    localparam logic [1:0] UPDI_SIZE_BYTE   = 2'b00;
    localparam logic [1:0] UPDI_SIZE_WORD   = 2'b01;

    typedef enum logic [3:0] {
        MR_IDLE,
        MR_PTR_ISSUE,
        MR_PTR_WAIT,
        MR_REP_ISSUE,
        MR_REP_WAIT,
        MR_LD_ISSUE,
        MR_LD_WAIT,
        MR_RX_WAIT,
        MR_FINISH
    } mem_reader_state_t;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_PULSE,
        HS_GUARD,
        HS_ARMED
    } hs_phase_t;

endpackage

// File: rtl/updi_tx_rx_handshake.sv
// Start-pulse / wait-for-ready helper: one-cycle start pulse,
// ignores ready while the far side reacts, then reports completion.
module updi_tx_rx_handshake
    import updi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    input  logic abort,
    output logic start,
    output logic fire,
    output logic complete
);

    hs_phase_t phase;

    assign fire     = req && ready && !abort && (phase == HS_IDLE);
    assign complete = (phase == HS_ARMED) && ready;

    // Pulse start on fire; skip the pulse cycle and the one after it
    // so a stale ready from before the start is not taken as completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= HS_IDLE;
            start <= 1'b0;
        end else begin
            start <= fire;
            if (abort) begin
                phase <= HS_IDLE;
            end else begin
                unique case (phase)
                    HS_IDLE:  if (fire) phase <= HS_PULSE;
                    HS_PULSE: phase <= HS_GUARD;
                    HS_GUARD: phase <= HS_ARMED;
                    HS_ARMED: if (ready) phase <= HS_IDLE;
                    default:  phase <= HS_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/updi_mem_reader.sv
// Sequencer turning "read N bytes at A" into ST_PTR, REPEAT, LD *(ptr++).
// Optional wait-state watchdog: define UPDI_MEM_READER_TIMEOUT_EN.
module updi_mem_reader
    import updi_pkg::*;
#(
    parameter int MAX_DATA_SIZE  = 16,
    parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [15:0]                     cmd_addr,
    input  logic [DATA_ADDR_BITS-1:0]       cmd_len,
    output logic                            done,
    output logic                            error,
    output logic                            instr_converter_en,
    output updi_instruction                 instruction,
    output logic [1:0]                      size_a,
    output logic [1:0]                      size_b,
    output logic [1:0]                      ptr,
    output logic [1:0]                      size_c,
    output logic [3:0]                      cs_addr,
    output logic                            sib,
    output logic [MAX_DATA_SIZE-1:0][7:0]   data,
    output logic [DATA_ADDR_BITS-1:0]       data_len,
    output logic [MAX_DATA_SIZE-1:0]        wait_ack_after,
    output logic                            tx_start,
    input  logic                            tx_ready,
    output logic [DATA_ADDR_BITS-1:0]       rx_n_bytes,
    output logic                            rx_start,
    input  logic                            rx_ready,
    input  logic                            rx_done,
    input  logic                            ack_error
);

    mem_reader_state_t         state;
    logic [DATA_ADDR_BITS-1:0] len_q;
    logic                      tx_fin;

    logic accept;
    logic tx_req;
    logic tx_fire;
    logic tx_complete;
    logic ptr_fail;
    logic abort;
    logic rx_fire;
    logic tmo_hit;

    assign cs_addr = 4'd0;
    assign sib     = 1'b0;
    assign size_c  = 2'b00;

    assign accept   = cmd_valid && cmd_ready && (state == MR_IDLE);
    assign tx_req   = state inside {MR_PTR_ISSUE, MR_REP_ISSUE, MR_LD_ISSUE};
    assign ptr_fail = (state == MR_PTR_WAIT) && ack_error;
    assign abort    = ptr_fail || tmo_hit;
    assign rx_fire  = (state == MR_LD_WAIT) && (tx_fin || tx_complete)
                      && rx_ready && !abort;

    updi_tx_rx_handshake u_tx_hs (
        .clk      (clk),
        .rst      (rst),
        .req      (tx_req),
        .ready    (tx_ready),
        .abort    (abort),
        .start    (tx_start),
        .fire     (tx_fire),
        .complete (tx_complete)
    );

`ifdef UPDI_MEM_READER_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        in_wait;

    assign in_wait = state inside {MR_PTR_WAIT, MR_REP_WAIT,
                                   MR_LD_WAIT, MR_RX_WAIT};
    assign tmo_hit = in_wait && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Watchdog: restart on every entry to a wait state, count while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= 16'd0;
        end else if (tx_fire || rx_fire) begin
            tmo_cnt <= 16'd0;
        end else if (in_wait) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    // No watchdog: wait states may wait forever; the limit is inert.
    assign tmo_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // Main sequencer: registered outputs loaded on entry to each issue state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= MR_IDLE;
            len_q              <= '0;
            tx_fin             <= 1'b0;
            cmd_ready          <= 1'b0;
            done               <= 1'b0;
            error              <= 1'b0;
            instr_converter_en <= 1'b0;
            instruction        <= UPDI_LDS;
            size_a             <= 2'b00;
            size_b             <= 2'b00;
            ptr                <= 2'b00;
            data               <= '0;
            data_len           <= '0;
            wait_ack_after     <= '0;
            rx_n_bytes         <= '0;
            rx_start           <= 1'b0;
        end else begin
            done     <= 1'b0;
            rx_start <= rx_fire;
            unique case (state)
                MR_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        len_q     <= cmd_len;
                        error     <= 1'b0;
                        if (cmd_len == '0) begin
                            state <= MR_FINISH;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            state              <= MR_PTR_ISSUE;
                            instr_converter_en <= 1'b1;
                            instruction        <= UPDI_ST_PTR;
                            ptr                <= UPDI_PTR_ADDRESS;
                            size_a             <= UPDI_SIZE_WORD;
                            size_b             <= 2'b00;
                            data               <= '0;
                            data[0]            <= cmd_addr[7:0];
                            data[1]            <= cmd_addr[15:8];
                            data_len           <= DATA_ADDR_BITS'(2);
                            wait_ack_after     <= MAX_DATA_SIZE'(2'b10);
                            rx_n_bytes         <= '0;
                        end
                    end
                end
                MR_PTR_ISSUE, MR_REP_ISSUE, MR_LD_ISSUE: begin
                    if (tx_fire) begin
                        unique case (state)
                            MR_PTR_ISSUE: state <= MR_PTR_WAIT;
                            MR_REP_ISSUE: state <= MR_REP_WAIT;
                            default:      state <= MR_LD_WAIT;
                        endcase
                    end
                end
                MR_PTR_WAIT: begin
                    if (abort) begin
                        state <= MR_FINISH;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else if (tx_complete && (len_q > DATA_ADDR_BITS'(1))) begin
                        state          <= MR_REP_ISSUE;
                        instruction    <= UPDI_REPEAT;
                        ptr            <= 2'b00;
                        size_a         <= 2'b00;
                        size_b         <= UPDI_SIZE_BYTE;
                        data           <= '0;
                        data[0]        <= 8'(len_q - DATA_ADDR_BITS'(1));
                        data_len       <= DATA_ADDR_BITS'(1);
                        wait_ack_after <= '0;
                    end else if (tx_complete) begin
                        state          <= MR_LD_ISSUE;
                        instruction    <= UPDI_LD;
                        ptr            <= UPDI_PTR_INC;
                        size_a         <= UPDI_SIZE_BYTE;
                        size_b         <= 2'b00;
                        data           <= '0;
                        data_len       <= '0;
                        wait_ack_after <= '0;
                        rx_n_bytes     <= len_q;
                    end
                end
                MR_REP_WAIT: begin
                    if (abort) begin
                        state <= MR_FINISH;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else if (tx_complete) begin
                        state          <= MR_LD_ISSUE;
                        instruction    <= UPDI_LD;
                        ptr            <= UPDI_PTR_INC;
                        size_a         <= UPDI_SIZE_BYTE;
                        size_b         <= 2'b00;
                        data           <= '0;
                        data_len       <= '0;
                        wait_ack_after <= '0;
                        rx_n_bytes     <= len_q;
                    end
                end
                MR_LD_WAIT: begin
                    if (abort) begin
                        state  <= MR_FINISH;
                        done   <= 1'b1;
                        error  <= 1'b1;
                        tx_fin <= 1'b0;
                    end else if (rx_fire) begin
                        state  <= MR_RX_WAIT;
                        tx_fin <= 1'b0;
                    end else if (tx_complete) begin
                        tx_fin <= 1'b1;
                    end
                end
                MR_RX_WAIT: begin
                    if (abort) begin
                        state <= MR_FINISH;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else if (rx_done) begin
                        state <= MR_FINISH;
                        done  <= 1'b1;
                        error <= 1'b0;
                    end
                end
                MR_FINISH: begin
                    state              <= MR_IDLE;
                    cmd_ready          <= 1'b1;
                    instr_converter_en <= 1'b0;
                    instruction        <= UPDI_LDS;
                    ptr                <= 2'b00;
                    size_a             <= 2'b00;
                    size_b             <= 2'b00;
                    data               <= '0;
                    data_len           <= '0;
                    wait_ack_after     <= '0;
                    rx_n_bytes         <= '0;
                end
                default: state <= MR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_updi_mem_reader.sv
// Directed bench for updi_mem_reader with a small updi_interface model.
// Timeout case runs only when UPDI_MEM_READER_TIMEOUT_EN is defined.
module tb_updi_mem_reader;
    import updi_pkg::*;

    localparam int MDS = 16;
    localparam int AW  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [15:0]           cmd_addr;
    logic [AW-1:0]         cmd_len;
    logic                  done;
    logic                  error;
    logic                  instr_converter_en;
    updi_instruction       instruction;
    logic [1:0]            size_a, size_b, ptr, size_c;
    logic [3:0]            cs_addr;
    logic                  sib;
    logic [MDS-1:0][7:0]   data;
    logic [AW-1:0]         data_len;
    logic [MDS-1:0]        wait_ack_after;
    logic                  tx_start;
    logic                  tx_ready;
    logic [AW-1:0]         rx_n_bytes;
    logic                  rx_start;
    logic                  rx_ready;
    logic                  rx_done;
    logic                  ack_error;

    always #5 clk = ~clk;

    updi_mem_reader #(
        .MAX_DATA_SIZE  (MDS),
        .DATA_ADDR_BITS (AW),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_addr           (cmd_addr),
        .cmd_len            (cmd_len),
        .done               (done),
        .error              (error),
        .instr_converter_en (instr_converter_en),
        .instruction        (instruction),
        .size_a             (size_a),
        .size_b             (size_b),
        .ptr                (ptr),
        .size_c             (size_c),
        .cs_addr            (cs_addr),
        .sib                (sib),
        .data               (data),
        .data_len           (data_len),
        .wait_ack_after     (wait_ack_after),
        .tx_start           (tx_start),
        .tx_ready           (tx_ready),
        .rx_n_bytes         (rx_n_bytes),
        .rx_start           (rx_start),
        .rx_ready           (rx_ready),
        .rx_done            (rx_done),
        .ack_error          (ack_error)
    );

    typedef struct {
        updi_instruction instr;
        logic [1:0]      ptr;
        logic [1:0]      size_a;
        logic [1:0]      size_b;
        logic [7:0]      d0;
        logic [7:0]      d1;
        logic [AW-1:0]   dlen;
        logic [MDS-1:0]  wack;
        logic [AW-1:0]   rxn;
    } txlog_t;

    txlog_t txq[$];
    int     n_rx      = 0;
    int     n_done    = 0;
    int     n_overlap = 0;
    int     tx_busy   = 0;
    int     rx_cnt    = 0;
    bit     inject_ack = 1'b0;
    bit     hold_rx    = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    // Interface model: logs each instruction at its tx_start, answers
    // with a few busy cycles, optional ACK error, and an rx_done.
    always @(negedge clk) begin
        if (rst) begin
            tx_ready  <= 1'b1;
            ack_error <= 1'b0;
            rx_done   <= 1'b0;
            tx_busy   <= 0;
            rx_cnt    <= 0;
        end else begin
            ack_error <= 1'b0;
            rx_done   <= 1'b0;
            if (tx_start && rx_start) n_overlap <= n_overlap + 1;
            if (done) n_done <= n_done + 1;
            if (tx_start) begin
                txq.push_back('{instruction, ptr, size_a, size_b,
                                data[0], data[1], data_len,
                                wait_ack_after, rx_n_bytes});
                tx_ready <= 1'b0;
                tx_busy  <= 3;
                if (instruction == UPDI_ST_PTR && inject_ack)
                    ack_error <= 1'b1;
            end else if (tx_busy > 0) begin
                tx_busy <= tx_busy - 1;
                if (tx_busy == 1) tx_ready <= 1'b1;
            end
            if (rx_start) begin
                n_rx   <= n_rx + 1;
                rx_cnt <= 3;
            end else if (rx_cnt > 0) begin
                rx_cnt <= rx_cnt - 1;
                if (rx_cnt == 1 && !hold_rx) rx_done <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_req(input logic [15:0] a, input logic [AW-1:0] l,
                           output int lat, output bit ok);
        int k;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        ok = done;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ready"}, 32'(cmd_ready), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_en"}, 32'(instr_converter_en), 0);
        chk({tag, "_instr"}, 32'(instruction), 0);
        chk({tag, "_data0"}, 32'(data == '0), 1);
        chk({tag, "_dlen"}, 32'(data_len), 0);
        chk({tag, "_wack"}, 32'(wait_ack_after), 0);
        chk({tag, "_txs"}, 32'(tx_start), 0);
        chk({tag, "_rxs"}, 32'(rx_start), 0);
        chk({tag, "_rxn"}, 32'(rx_n_bytes), 0);
        chk({tag, "_ptrsz"}, {24'd0, ptr, size_a, size_b, size_c}, 0);
        chk({tag, "_cs_sib"}, {27'd0, cs_addr, sib}, 0);
    endtask

    typedef struct {
        logic [15:0]   addr;
        logic [AW-1:0] len;
        bit            ack;
        bit            exp_err;
        int            exp_ntx;
        int            exp_nrx;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int     lat;
        bit     ok;
        int     btx, brx, bdone, j, k;
        txlog_t e;

        vecs[0] = '{16'h1234, 4'd4,  1'b0, 1'b0, 3, 1};
        vecs[1] = '{16'h0F00, 4'd1,  1'b0, 1'b0, 2, 1};
        vecs[2] = '{16'hABCD, 4'd0,  1'b0, 1'b1, 0, 0};
        vecs[3] = '{16'h5A5A, 4'd15, 1'b0, 1'b0, 3, 1};
        vecs[4] = '{16'h00FF, 4'd2,  1'b1, 1'b1, 1, 0};
        vecs[5] = '{16'hFFFF, 4'd2,  1'b0, 1'b0, 3, 1};

        rx_ready  = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 16'h0;
        cmd_len   = '0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        #1;
        chk("ready_before_edge", 32'(cmd_ready), 0);
        @(negedge clk);
        chk("ready_after_edge", 32'(cmd_ready), 1);

        for (int i = 0; i < 6; i++) begin
            btx = txq.size();
            brx = n_rx;
            inject_ack = vecs[i].ack;
            run_req(vecs[i].addr, vecs[i].len, lat, ok);
            chk($sformatf("v%0d_done", i), 32'(ok), 1);
            chk($sformatf("v%0d_error", i), 32'(error), 32'(vecs[i].exp_err));
            if (vecs[i].len == '0)
                chk($sformatf("v%0d_zero_lat", i), 32'(lat <= 3), 1);
            @(negedge clk);
            inject_ack = 1'b0;
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 0);
            chk($sformatf("v%0d_ready_back", i), 32'(cmd_ready), 1);
            chk($sformatf("v%0d_ntx", i), 32'(txq.size() - btx),
                32'(vecs[i].exp_ntx));
            chk($sformatf("v%0d_nrx", i), 32'(n_rx - brx),
                32'(vecs[i].exp_nrx));
            if (txq.size() - btx >= 1) begin
                e = txq[btx];
                chk($sformatf("v%0d_p_instr", i), 32'(e.instr), 32'(UPDI_ST_PTR));
                chk($sformatf("v%0d_p_d0", i), 32'(e.d0), 32'(vecs[i].addr[7:0]));
                chk($sformatf("v%0d_p_d1", i), 32'(e.d1), 32'(vecs[i].addr[15:8]));
                chk($sformatf("v%0d_p_dlen", i), 32'(e.dlen), 2);
                chk($sformatf("v%0d_p_wack", i), 32'(e.wack), 32'h2);
                chk($sformatf("v%0d_p_ptr", i), {28'd0, e.ptr, e.size_a}, 32'h9);
            end
            if (vecs[i].exp_ntx == 3 && txq.size() - btx == 3) begin
                e = txq[btx + 1];
                chk($sformatf("v%0d_r_instr", i), 32'(e.instr), 32'(UPDI_REPEAT));
                chk($sformatf("v%0d_r_d0", i), 32'(e.d0), 32'(vecs[i].len) - 1);
                chk($sformatf("v%0d_r_dlen", i), 32'(e.dlen), 1);
                chk($sformatf("v%0d_r_wack_sb", i), {14'd0, e.wack, e.size_b}, 0);
            end
            if (vecs[i].exp_nrx == 1 && txq.size() - btx == vecs[i].exp_ntx) begin
                e = txq[btx + vecs[i].exp_ntx - 1];
                chk($sformatf("v%0d_l_instr", i), 32'(e.instr), 32'(UPDI_LD));
                chk($sformatf("v%0d_l_ptr", i), {28'd0, e.ptr, e.size_a}, 32'h4);
                chk($sformatf("v%0d_l_dlen", i), 32'(e.dlen), 0);
                chk($sformatf("v%0d_l_rxn", i), 32'(e.rxn), 32'(vecs[i].len));
            end
        end

        // Reset pulsed while waiting for rx_done.
        hold_rx   = 1'b1;
        cmd_addr  = 16'h2222;
        cmd_len   = 4'd3;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!rx_start && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("mid_rx_start_seen", 32'(rx_start), 1);
        @(negedge clk);
        @(negedge clk);
        bdone = n_done;
        #2 rst = 1'b1;
        #1;
        chk_outputs_zero("mid_rst");
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        hold_rx = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_no_done", 32'(n_done - bdone), 0);
        btx = txq.size();
        run_req(16'h4321, 4'd2, lat, ok);
        chk("post_rst_done", 32'(ok), 1);
        chk("post_rst_error", 32'(error), 0);
        @(negedge clk);
        chk("post_rst_ntx", 32'(txq.size() - btx), 3);

`ifdef UPDI_MEM_READER_TIMEOUT_EN
        hold_rx   = 1'b1;
        cmd_addr  = 16'h0100;
        cmd_len   = 4'd2;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!rx_start && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_rx_start_seen", 32'(rx_start), 1);
        j = 0;
        while (!done && j < 300) begin
            @(negedge clk);
            j++;
        end
        chk("tmo_cycles", 32'(j), 100);
        chk("tmo_error", 32'(error), 1);
        hold_rx = 1'b0;
        repeat (2) @(negedge clk);
`endif

        chk("tx_rx_overlap", 32'(n_overlap), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/updi_mem_reader.md
Name: updi_mem_reader

Overview:
- Upstream command sequencer for updi_interface.
- Turns one high-level "read N bytes from 16-bit address A" request into three instructions: ST_PTR (address, ACK-checked), optional REPEAT, then LD *(ptr++).
- Drives the interface's instruction, data, tx and rx control inputs.
- Received bytes go to the output RX FIFO through updi_interface; this block reports only completion and error status.

Parameters:
- MAX_DATA_SIZE, 16, depth of the interface data array; must match updi_interface.
- DATA_ADDR_BITS, $clog2(MAX_DATA_SIZE), width of length fields.
- TIMEOUT_CYCLES, 65535, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  read request valid
- cmd_ready  out  1  sequencer idle, can accept a request
- cmd_addr  in  16  UPDI data-space start address
- cmd_len  in  DATA_ADDR_BITS  byte count; legal range 1..MAX_DATA_SIZE-1
- done  out  1  one-cycle pulse, request finished (success or error)
- error  out  1  valid with done: 1 means ACK error, zero length, or timeout
- instr_converter_en  out  1  to updi_interface
- instruction  out  updi_instruction  to updi_interface
- size_a, size_b, ptr, size_c  out  2 each  to updi_interface
- cs_addr  out  4  tied 0
- sib  out  1  tied 0
- data  out  8 x MAX_DATA_SIZE  instruction payload
- data_len  out  DATA_ADDR_BITS  payload length
- wait_ack_after  out  MAX_DATA_SIZE  per-byte ACK request mask
- tx_start  out  1;  tx_ready  in  1
- rx_n_bytes  out  DATA_ADDR_BITS
- rx_start  out  1
- rx_ready, rx_done, ack_error  in  1 each

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs are 0, including data, data_len and wait_ack_after.
  - cmd_ready rises the first cycle after rst deasserts.
- Request accept: accepted on a clock edge with cmd_valid & cmd_ready. cmd_addr and cmd_len are registered; cmd_ready drops the next cycle.
- Zero length: cmd_len==0 goes to FINISH with error=1. Nothing is sent on UPDI.
- FSM states:
  - IDLE -> PTR_ISSUE.
  - PTR_ISSUE:
    - instruction=ST_PTR, ptr=2'b10 (pointer write), size_a=2'b01 (16-bit address).
    - data[0]=addr[7:0], data[1]=addr[15:8], data_len=2, wait_ack_after=bit1 only.
    - instr_converter_en=1. When tx_ready=1, pulse tx_start for 1 cycle, then go to PTR_WAIT.
  - PTR_WAIT:
    - tx_ready is ignored in the first cycle after the tx_start pulse.
    - Afterwards, tx_ready=1 moves to REP_ISSUE if len>1, else LD_ISSUE.
    - ack_error=1 in any cycle of PTR_WAIT moves to FINISH with error=1; this takes priority over tx_ready.
  - REP_ISSUE:
    - instruction=REPEAT, size_b=2'b00, data[0]=len-1, data_len=1, wait_ack_after=0.
    - Same start rule as PTR_ISSUE, followed by REP_WAIT (same wait rule; no ACK check).
  - LD_ISSUE:
    - instruction=LD, ptr=2'b01 (*ptr++), size_a=2'b00 (byte), data_len=0, rx_n_bytes=len.
    - Pulse tx_start when tx_ready=1, then go to LD_WAIT.
  - LD_WAIT: after tx completes (same rule), pulse rx_start for 1 cycle as soon as rx_ready=1, then go to RX_WAIT.
  - RX_WAIT: rx_done=1 moves to FINISH with error=0.
  - FINISH: done=1 for exactly one cycle, error held; next state IDLE. error clears when the next request is accepted.
- Output hold: instruction-side outputs stay stable from the issue state until the matching wait state exits.
- Interlocks:
  - tx_start and rx_start are never high simultaneously.
  - cmd_valid outside IDLE is ignored.
- Length arithmetic: len-1 is computed in DATA_ADDR_BITS with no wrap, since len is at least 1 at that point.
- Reset mid-operation: immediately returns to IDLE with all outputs 0; no done pulse.

Optional Feature:
- Macro: UPDI_MEM_READER_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to every WAIT state and increments each cycle spent in PTR_WAIT, REP_WAIT, LD_WAIT or RX_WAIT.
  - Reaching TIMEOUT_CYCLES moves to FINISH with error=1.
- When undefined: no counter is built and the WAIT states may wait forever.

Decomposition:
- updi_pkg (existing shared package) holds:
  - the updi_instruction enum;
  - new constants UPDI_PTR_ADDRESS=2'b10, UPDI_PTR_INC=2'b01, UPDI_SIZE_BYTE=2'b00, UPDI_SIZE_WORD=2'b01;
  - the mem_reader state enum.
- Sub-module updi_tx_rx_handshake (start-pulse/wait-for-ready helper) is natural; the FSM instantiates it once for tx.

Test Plan:
- Request addr=0x1234, len=4, interface model ACKs ->
  - ST_PTR payload {0x34,0x12}, wait_ack_after=0b10;
  - REPEAT payload {0x03};
  - LD with rx_n_bytes=4;
  - one rx_start pulse; done=1, error=0.
- len=1, addr=0x0F00 -> no REPEAT issued; LD directly after ST_PTR; done, error=0.
- len=0 -> no tx_start ever; done=1 with error=1 within 3 cycles of accept.
- ack_error asserted during PTR_WAIT -> no REPEAT/LD issued; done=1, error=1; cmd_ready returns next cycle.
- rst pulsed during RX_WAIT -> all outputs 0 asynchronously, no done pulse; new request afterwards completes normally.
- With UPDI_MEM_READER_TIMEOUT_EN, TIMEOUT_CYCLES=100, rx_done withheld -> done=1, error=1 exactly 100 cycles after entering RX_WAIT.
